// File: rtl/axi_line_read_bridge_pkg.sv
// rtl/axi_line_read_bridge_pkg.sv - AXI constants, FSM state type and line geometry helper for the line read bridge
package axi_line_read_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic int word_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/axi_line_read_bridge_rr_arbiter.sv
// rtl/axi_line_read_bridge_rr_arbiter.sv - round-robin arbiter: first requester at or after ptr wins, one-hot grant
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_line_read_bridge.sv
// rtl/axi_line_read_bridge.sv - arbitrates client line reads into single AXI bursts and returns assembled lines
// Optional CRITICAL_WORD_FIRST_EN: WRAP burst from the requested word instead of INCR from the line start.
module axi_line_read_bridge
    import axi_line_read_bridge_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int LINE_WORDS  = 4,
    parameter int ID_BASE     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CLIENTS-1:0]     req_valid,
    output logic [NUM_CLIENTS-1:0]     req_ready,
    input  logic [32*NUM_CLIENTS-1:0]  req_addr,
    output logic [NUM_CLIENTS-1:0]     resp_valid,
    input  logic [NUM_CLIENTS-1:0]     resp_ready,
    output logic [32*LINE_WORDS-1:0]   resp_line,
    output logic                       resp_err,
    output logic                       ar_valid,
    input  logic                       ar_ready,
    output logic [3:0]                 ar_id,
    output logic [31:0]                ar_addr,
    output logic [3:0]                 ar_len,
    output logic [2:0]                 ar_size,
    output logic [1:0]                 ar_burst,
    output logic [1:0]                 ar_lock,
    output logic [3:0]                 ar_cache,
    output logic [2:0]                 ar_prot,
    input  logic                       r_valid,
    output logic                       r_ready,
    input  logic [3:0]                 r_id,
    input  logic [31:0]                r_data,
    input  logic [1:0]                 r_resp,
    input  logic                       r_last
);

    localparam int OW = word_off_w(LINE_WORDS);
    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    state_t                       state, state_next;
    logic [PW-1:0]                ptr, ptr_next, gidx_q, gidx_c;
    logic [NUM_CLIENTS-1:0]       grant;
    logic [31:0]                  sel_addr, addr_q, aligned;
    logic [OW-1:0]                cnt, start;
    logic [OW:0]                  beats;
    logic                         err, ar_valid_q, ar_hs, in_range;
    logic [LINE_WORDS-1:0][31:0]  line_q;

    rr_arbiter #(.N(NUM_CLIENTS), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gidx_c   = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                gidx_c   = PW'(i);
                sel_addr = req_addr[32*i +: 32];
            end
        end
        ptr_next = (int'(gidx_c) == NUM_CLIENTS - 1) ? '0 : gidx_c + 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
        aligned = sel_addr & ~32'h3;
        start   = OW'(sel_addr >> 2);
`else
        aligned = sel_addr & ~32'(LINE_WORDS * 4 - 1);
        start   = '0;
`endif
    end

    assign ar_hs    = ar_valid_q && ar_ready;
    assign in_range = beats < (OW+1)'(LINE_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx_q     <= '0;
            addr_q     <= '0;
            cnt        <= '0;
            beats      <= '0;
            err        <= 1'b0;
            ar_valid_q <= 1'b0;
            line_q     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (|req_valid) begin
                    gidx_q <= gidx_c;
                    ptr    <= ptr_next;
                    addr_q <= aligned;
                    cnt    <= start;
                    beats  <= '0;
                    err    <= 1'b0;
                    line_q <= '0;
                end
                // ar_valid comes from a flop so it rises one cycle after entering ADDR
                ADDR: ar_valid_q <= !ar_hs;
                DATA: if (r_valid) begin
                    if (in_range) begin
                        line_q[cnt] <= r_data;
                        cnt         <= cnt + 1'b1;
                        beats       <= beats + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    if (r_resp != RESP_OKAY || r_id != ar_id)
                        err <= 1'b1;
                    if (r_last && beats < (OW+1)'(LINE_WORDS - 1))
                        err <= 1'b1;
                end
                RESP: if (resp_ready[gidx_q]) err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (|req_valid) state_next = ADDR;
            ADDR: if (ar_hs) state_next = DATA;
            DATA: if (r_valid && r_last) state_next = RESP;
            RESP: if (resp_ready[gidx_q]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) ? grant : '0;
        r_ready    = (state == DATA);
        resp_valid = (state == RESP) ? (NUM_CLIENTS'(1) << gidx_q) : '0;
    end

    assign resp_line = line_q;
    assign resp_err  = err;
    assign ar_valid  = ar_valid_q;
    assign ar_id     = 4'(ID_BASE) + 4'(gidx_q);
    assign ar_addr   = addr_q;
    assign ar_len    = 4'(LINE_WORDS - 1);
    assign ar_size   = SIZE_4B;
`ifdef CRITICAL_WORD_FIRST_EN
    assign ar_burst  = BURST_WRAP;
`else
    assign ar_burst  = BURST_INCR;
`endif
    assign ar_lock   = 2'b00;
    assign ar_cache  = 4'b0000;
    assign ar_prot   = 3'b000;

endmodule

// File: tb/tb_axi_line_read_bridge.sv
// tb/tb_axi_line_read_bridge.sv - randomized scoreboard bench for axi_line_read_bridge
module tb_axi_line_read_bridge;

    localparam int N   = 2;
    localparam int LW  = 4;
    localparam int IDB = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [32*N-1:0]   req_addr;
    logic [32*LW-1:0]  resp_line;
    logic              resp_err, ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [3:0]        ar_id, ar_len, ar_cache, r_id;
    logic [31:0]       ar_addr, r_data;
    logic [2:0]        ar_size, ar_prot;
    logic [1:0]        ar_burst, ar_lock, r_resp;

    axi_line_read_bridge #(.NUM_CLIENTS(N), .LINE_WORDS(LW), .ID_BASE(IDB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line), .resp_err(resp_err),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
    );

`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct {
        int               nbeats;
        int               bad_beat;
        int               bad_id_beat;
        logic [3:0]       id;
        logic [19:0][31:0] data;
    } plan_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
    } exp_ar_t;

    typedef struct {
        int           client;
        logic [127:0] line;
        logic         err;
    } exp_resp_t;

    plan_t     plan_q[$];
    exp_ar_t   exp_ar_q[$];
    exp_resp_t exp_resp_q[$];

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Builds the expected grant order and outcome of one round, drives the requests and waits for completion.
    task automatic do_round(input logic [N-1:0] set, input int mode, input int arg,
                            input bit fixed, input logic [31:0] faddr, input bit check_lat);
        logic [31:0]  a[N];
        int           order[$];
        logic [N-1:0] rem, pending, got;
        int           p, idx, n, c, m, start;
        bit           found;
        plan_t        pl;
        exp_resp_t    er;
        exp_ar_t      ea;
        for (int i = 0; i < N; i++) a[i] = fixed ? faddr : $urandom;
        rem = set;
        p   = model_ptr;
        while (rem != 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (p + k) % N;
                if (!found && rem[idx]) begin
                    found = 1;
                    order.push_back(idx);
                    rem[idx] = 1'b0;
                    p = (idx + 1) % N;
                end
            end
        end
        model_ptr = p;
        foreach (order[j]) begin
            c = order[j];
            m = (mode < 0) ? $urandom_range(0, 9) : mode;
            pl.nbeats = LW; pl.bad_beat = -1; pl.bad_id_beat = -1;
            pl.id = 4'(IDB + c);
            for (int w = 0; w < 20; w++) pl.data[w] = fixed ? 32'hA0 + w : $urandom;
            case (m)
                5: pl.bad_beat    = (arg >= 0) ? arg : $urandom_range(0, LW-1);
                6: pl.nbeats      = (arg >= 0) ? arg : $urandom_range(1, LW-1);
                7: pl.nbeats      = LW + $urandom_range(1, 3);
                8: pl.bad_id_beat = $urandom_range(0, LW-1);
                default: ;
            endcase
            start = CWF ? (a[c] >> 2) % LW : 0;
            ea.addr = CWF ? (a[c] & ~32'h3) : (a[c] & ~32'(LW*4 - 1));
            ea.id   = pl.id;
            er.client = c;
            er.line   = '0;
            for (int b = 0; b < pl.nbeats && b < LW; b++)
                er.line[32*((start + b) % LW) +: 32] = pl.data[b];
            er.err = (pl.nbeats != LW) || (pl.bad_beat >= 0) || (pl.bad_id_beat >= 0);
            plan_q.push_back(pl);
            exp_ar_q.push_back(ea);
            exp_resp_q.push_back(er);
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (set[i]) begin
            req_addr[32*i +: 32] = a[i];
            req_valid[i] = 1'b1;
        end
        pending = set;
        n = 0;
        while ((pending != 0 || exp_resp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            if (check_lat) begin
                if (n == 0) chk(req_ready == set, "req_ready_first_cycle", 128'(req_ready), 128'(set));
                if (n == 1) chk(ar_valid == 1'b0, "ar_valid_lat1", 128'(ar_valid), 128'(0));
                if (n == 2) chk(ar_valid == 1'b1, "ar_valid_lat2", 128'(ar_valid), 128'(1));
            end
            got = pending & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (got[i]) begin
                req_valid[i] = 1'b0;
                req_addr[32*i +: 32] = $urandom;
                pending[i] = 1'b0;
            end
            n++;
        end
        if (n >= 3000) chk(1'b0, "round_timeout", 128'(n), 128'(3000));
    endtask

    // AXI slave: answers each AR with the beat plan queued for it
    initial begin
        plan_t   pl;
        exp_ar_t ea;
        ar_ready = 0; r_valid = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0;
        forever begin
            @(negedge clk);
            if (rst_n && ar_valid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (exp_ar_q.size() == 0) begin
                    chk(1'b0, "ar_unexpected", 128'(ar_addr), 128'(0));
                    pl.nbeats = 1; pl.bad_beat = -1; pl.bad_id_beat = -1; pl.id = ar_id; pl.data = '0;
                end else begin
                    ea = exp_ar_q.pop_front();
                    pl = plan_q.pop_front();
                    chk(ar_addr == ea.addr, "ar_addr", 128'(ar_addr), 128'(ea.addr));
                    chk(ar_id == ea.id, "ar_id", 128'(ar_id), 128'(ea.id));
                    chk(ar_len == 4'(LW-1), "ar_len", 128'(ar_len), 128'(LW-1));
                    chk(ar_burst == (CWF ? 2'b10 : 2'b01), "ar_burst", 128'(ar_burst), 128'(CWF ? 2 : 1));
                    chk(ar_size == 3'b010 && ar_lock == 0 && ar_cache == 0 && ar_prot == 0, "ar_const",
                        {ar_size, ar_lock, ar_cache, ar_prot}, {3'b010, 9'b0});
                end
                ar_ready = 1;
                @(negedge clk);
                ar_ready = 0;
                for (int j = 0; j < pl.nbeats; j++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    r_valid = 1;
                    r_data  = pl.data[j];
                    r_resp  = (j == pl.bad_beat) ? 2'b10 : 2'b00;
                    r_id    = (j == pl.bad_id_beat) ? (pl.id ^ 4'h1) : pl.id;
                    r_last  = (j == pl.nbeats - 1);
                    chk(r_ready == 1'b1, "r_ready_in_burst", 128'(r_ready), 128'(1));
                    @(negedge clk);
                    r_valid = 0;
                    r_last  = 0;
                end
            end
        end
    end

    initial begin
        resp_ready = '0;
        forever begin
            @(posedge clk); #1;
            resp_ready = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
        end
    end

    // Response monitor: compares each consumed line against the scoreboard and checks hold while stalled
    logic [127:0] prev_line;
    logic         prev_err;
    logic [N-1:0] prev_rv;
    bit           waiting = 0;
    exp_resp_t    er_m;
    always @(negedge clk) begin
        if (rst_n) begin
            if (waiting)
                chk(resp_valid == prev_rv && resp_line == prev_line && resp_err == prev_err, "resp_hold",
                    {resp_err, resp_line[126:0]}, {prev_err, prev_line[126:0]});
            waiting = 0;
            if (resp_valid != 0) begin
                chk(ar_valid == 1'b0, "no_ar_during_resp", 128'(ar_valid), 128'(0));
                for (int i = 0; i < N; i++) if (resp_valid[i]) begin
                    if (resp_ready[i]) begin
                        if (exp_resp_q.size() == 0) chk(1'b0, "resp_unexpected", 128'(i), 128'(0));
                        else begin
                            er_m = exp_resp_q.pop_front();
                            chk(i == er_m.client, "resp_client", 128'(i), 128'(er_m.client));
                            chk(resp_line == er_m.line, "resp_line", resp_line, er_m.line);
                            chk(resp_err == er_m.err, "resp_err", 128'(resp_err), 128'(er_m.err));
                        end
                    end else begin
                        waiting   = 1;
                        prev_rv   = resp_valid;
                        prev_line = resp_line;
                        prev_err  = resp_err;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 0; req_valid = '0; req_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ar_valid == 0 && r_ready == 0 && resp_valid == 0 && req_ready == 0, "reset_ctrl",
            {ar_valid, r_ready, resp_valid, req_ready}, 128'(0));
        chk(resp_line == 0 && resp_err == 0 && ar_addr == 0 && ar_id == 4'(IDB), "reset_data",
            {resp_err, resp_line[126:0]}, 128'(0));
        rst_n = 1;
        do_round(2'b01, 0, -1, 1, 32'h1000_0014, 1);
        repeat (3) do_round(2'b11, 0, -1, 0, 0, 0);
        do_round(2'b01, 5, 2, 0, 0, 0);
        do_round(2'b10, 0, -1, 0, 0, 0);
        do_round(2'b01, 6, 2, 0, 0, 0);
        do_round(2'b10, 7, -1, 0, 0, 0);
        do_round(2'b11, 8, -1, 0, 0, 0);
        for (int r = 0; r < 40; r++) do_round(N'($urandom_range(1, (1 << N) - 1)), -1, -1, 0, 0, 0);
        repeat (5) @(posedge clk);
        chk(exp_resp_q.size() == 0 && exp_ar_q.size() == 0, "queues_drained",
            128'(exp_resp_q.size() + exp_ar_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
